// File: rtl/hft_pkg.sv
// Shared types and header layout for the order TX path.
// The two-beat frame is a magic/seq/idx/side header followed by the order price.
package hft_pkg;

   localparam logic [31:0] TX_MAGIC = 32'hDEADBEEF;

   localparam int HDR_MAGIC_LSB = 32;
   localparam int HDR_SEQ_LSB   = 24;
   localparam int HDR_IDX_LSB   = 16;
   localparam int HDR_SIDE_LSB  = 0;

   typedef enum logic [1:0] {
      IDLE,
      HDR,
      PAY,
      GAP
   } sched_state_t;

   function automatic logic [63:0] make_header(input logic [7:0] seq,
                                               input logic [2:0] idx,
                                               input logic       side);
      logic [63:0] h;
      h                         = '0;
      h[HDR_MAGIC_LSB +: 32]    = TX_MAGIC;
      h[HDR_SEQ_LSB +: 8]       = seq;
      h[HDR_IDX_LSB +: 3]       = idx;
      h[HDR_SIDE_LSB]           = side;
      return h;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: search starts one above last_grant and wraps.
// The grant pointer itself is held by the parent.
module rr_arbiter #(
   parameter int N = 4
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] last_grant,
   input  logic                 en,
   output logic [N-1:0]         grant,
   output logic [$clog2(N)-1:0] grant_idx
);

   localparam int IW = $clog2(N);

   int   idx;
   logic found;

   // NOTE: every output and temporary gets a default before the search loop;
   // a path that leaves one unassigned would infer a latch.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      idx       = 0;
      for (int k = 1; k <= N; k++) begin
         idx = (int'(last_grant) + k) % N;
         if (en && !found && req[idx]) begin
            grant[idx] = 1'b1;
            grant_idx  = IW'(idx);
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/tx_order_scheduler.sv
// Round-robin order scheduler onto the 64-bit TX port, two-beat framing,
// token-bucket rate limiting and throughput/throttle statistics.
module tx_order_scheduler #(
   parameter int NUM_REQ       = 4,
   parameter int TOKEN_MAX     = 8,
   parameter int REFILL_PERIOD = 16,
   parameter int GAP_CYCLES    = 1
) (
   input  logic                    clk_156mhz,
   input  logic                    rst,
   input  logic [NUM_REQ-1:0]      req_valid,
   input  logic [NUM_REQ*64-1:0]   req_price,
   input  logic [NUM_REQ-1:0]      req_side,
   output logic [NUM_REQ-1:0]      req_ready,
   input  logic                    halt,
   input  logic                    tx_ready,
   output logic [63:0]             tx_data,
   output logic                    tx_valid,
   output logic [31:0]             orders_sent,
   output logic [31:0]             throttle_cycles,
   output logic [3:0]              tokens
);

   import hft_pkg::*;

   localparam int IW = $clog2(NUM_REQ);
   localparam int RW = $clog2(REFILL_PERIOD);
   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   sched_state_t  state_q, state_d;
   logic [7:0]    seq_q, seq_d;
   logic [63:0]   price_q, price_d;
   logic [IW-1:0] last_grant_q, last_grant_d;
   logic [3:0]    tokens_q, tokens_d;
   logic [RW-1:0] refill_q, refill_d;
   logic [GW-1:0] gap_q, gap_d;
   logic          tx_valid_q, tx_valid_d;
   logic [63:0]   tx_data_q, tx_data_d;
   logic [31:0]   sent_q, sent_d;
   logic [31:0]   throttle_q, throttle_d;

   logic [NUM_REQ-1:0] grant;
   logic [IW-1:0]      grant_idx;
   logic               arb_en;
   logic               accept;
   logic               refill_wrap;

   assign arb_en      = (state_q == IDLE) && !halt && (tokens_q != 4'd0);
   assign accept      = |grant;
   assign refill_wrap = (refill_q == RW'(REFILL_PERIOD - 1));

   rr_arbiter #(.N(NUM_REQ)) u_arb (
      .req        (req_valid),
      .last_grant (last_grant_q),
      .en         (arb_en),
      .grant      (grant),
      .grant_idx  (grant_idx)
   );

   always_comb begin
      state_d      = state_q;
      seq_d        = seq_q;
      price_d      = price_q;
      last_grant_d = last_grant_q;
      gap_d        = gap_q;
      tx_valid_d   = tx_valid_q;
      tx_data_d    = tx_data_q;
      sent_d       = sent_q;
      throttle_d   = throttle_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               seq_d        = seq_q + 8'd1;
               price_d      = req_price[64*int'(grant_idx) +: 64];
               last_grant_d = grant_idx;
               tx_valid_d   = 1'b1;
               tx_data_d    = make_header(seq_d, 3'(grant_idx), req_side[grant_idx]);
               state_d      = HDR;
            end else if (|req_valid && !halt && tokens_q == 4'd0) begin
               throttle_d = throttle_q + 32'd1;
            end
         end
         HDR: begin
            if (tx_ready) begin
               tx_data_d = price_q;
               state_d   = PAY;
            end
         end
         PAY: begin
            if (tx_ready) begin
               sent_d     = sent_q + 32'd1;
               tx_valid_d = 1'b0;
               tx_data_d  = '0;
               gap_d      = '0;
               state_d    = (GAP_CYCLES == 0) ? IDLE : GAP;
            end
         end
         GAP: begin
            if (32'(gap_q) + 32'd1 >= 32'(GAP_CYCLES)) state_d = IDLE;
            else                                       gap_d   = gap_q + GW'(1);
         end
         default: state_d = IDLE;
      endcase
   end

   // A refill and a consume landing on the same edge cancel out.
   always_comb begin
      tokens_d = tokens_q;
      refill_d = refill_wrap ? '0 : refill_q + RW'(1);
      if (refill_wrap && !accept)
         tokens_d = (tokens_q >= 4'(TOKEN_MAX)) ? 4'(TOKEN_MAX) : tokens_q + 4'd1;
      else if (!refill_wrap && accept)
         tokens_d = tokens_q - 4'd1;
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk_156mhz or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         seq_q        <= '0;
         price_q      <= '0;
         last_grant_q <= IW'(NUM_REQ - 1);
         tokens_q     <= 4'(TOKEN_MAX);
         refill_q     <= '0;
         gap_q        <= '0;
         tx_valid_q   <= 1'b0;
         tx_data_q    <= '0;
         sent_q       <= '0;
         throttle_q   <= '0;
      end else begin
         state_q      <= state_d;
         seq_q        <= seq_d;
         price_q      <= price_d;
         last_grant_q <= last_grant_d;
         tokens_q     <= tokens_d;
         refill_q     <= refill_d;
         gap_q        <= gap_d;
         tx_valid_q   <= tx_valid_d;
         tx_data_q    <= tx_data_d;
         sent_q       <= sent_d;
         throttle_q   <= throttle_d;
      end
   end

   assign req_ready       = grant;
   assign tx_valid        = tx_valid_q;
   assign tx_data         = tx_data_q;
   assign orders_sent     = sent_q;
   assign throttle_cycles = throttle_q;
   assign tokens          = tokens_q;

endmodule

// File: tb/tb_tx_order_scheduler.sv
// Directed bench for tx_order_scheduler: expected grants are queued with the
// stimulus, expected beats are derived at each grant and popped as the TX port fires.
module tb_tx_order_scheduler;

   localparam int N      = 4;
   localparam int REFILL = 64;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [N-1:0]      req_valid = '0;
   logic [N*64-1:0]   req_price = '0;
   logic [N-1:0]      req_side = '0;
   logic [N-1:0]      req_ready;
   logic              halt = 1'b0;
   logic              tx_ready = 1'b1;
   logic [63:0]       tx_data;
   logic              tx_valid;
   logic [31:0]       orders_sent;
   logic [31:0]       throttle_cycles;
   logic [3:0]        tokens;

   always #5 clk = ~clk;

   tx_order_scheduler #(
      .NUM_REQ(N), .TOKEN_MAX(8), .REFILL_PERIOD(REFILL), .GAP_CYCLES(1)
   ) dut (
      .clk_156mhz      (clk),
      .rst             (rst),
      .req_valid       (req_valid),
      .req_price       (req_price),
      .req_side        (req_side),
      .req_ready       (req_ready),
      .halt            (halt),
      .tx_ready        (tx_ready),
      .tx_data         (tx_data),
      .tx_valid        (tx_valid),
      .orders_sent     (orders_sent),
      .throttle_cycles (throttle_cycles),
      .tokens          (tokens)
   );

   typedef struct {
      logic [63:0] data;
      bit          last;
   } beat_t;

   beat_t beats[$];
   int    grants[$];
   int    pend[N];
   int    seq_m;
   int    exp_sent;
   int    cyc;
   int    last_acc_cyc;
   int    n_checks = 0;
   int    n_err = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic update_req();
      for (int i = 0; i < N; i++) req_valid[i] = (pend[i] > 0);
   endtask

   // One clock: score grants/beats at the negedge, then advance past the posedge.
   task automatic tick();
      logic [N-1:0] rr;
      beat_t        b;
      int           gi;
      gi = -1;
      @(negedge clk);
      rr = req_ready;
      if (rr !== '0) begin
         if (grants.size() == 0) begin
            check("unexpected_grant", 64'(rr), 64'h0);
         end else begin
            gi = grants.pop_front();
            check("grant", 64'(rr), 64'(1 << gi));
            seq_m = (seq_m + 1) % 256;
            beats.push_back('{data: {32'hDEADBEEF, 8'(seq_m), 5'b0, 3'(gi), 15'b0, req_side[gi]},
                              last: 1'b0});
            beats.push_back('{data: req_price[64*gi +: 64], last: 1'b1});
            last_acc_cyc = cyc;
         end
      end
      if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
         if (beats.size() == 0) begin
            check("unexpected_beat", 64'(tx_valid), 64'h0);
         end else begin
            b = beats.pop_front();
            check(b.last ? "price_beat" : "header_beat", tx_data, b.data);
            if (b.last) exp_sent++;
         end
      end
      @(posedge clk);
      #1;
      cyc++;
      if (gi >= 0 && pend[gi] > 0) begin
         pend[gi]--;
         update_req();
      end
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      halt     = 1'b0;
      tx_ready = 1'b1;
      for (int i = 0; i < N; i++) pend[i] = 0;
      update_req();
      grants.delete();
      beats.delete();
      @(posedge clk);
      #1;
      rst      = 1'b0;
      cyc      = 0;
      seq_m    = 0;
      exp_sent = 0;
   endtask

   task automatic drain(input int max_cycles);
      for (int i = 0; i < max_cycles; i++) begin
         if (grants.size() == 0 && beats.size() == 0 && tx_valid === 1'b0) break;
         tick();
      end
      check("drain_outstanding", 64'(grants.size() + beats.size()), 64'h0);
   endtask

   task automatic wait_sent(input int n, input int max_cycles);
      for (int i = 0; i < max_cycles && exp_sent < n; i++) tick();
      check("wait_sent", 64'(exp_sent), 64'(n));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset and idle.
      do_reset();
      for (int i = 0; i < 20; i++) tick();
      check("idle_tx_valid", 64'(tx_valid), 64'h0);
      check("idle_tx_data", tx_data, 64'h0);
      check("idle_req_ready", 64'(req_ready), 64'h0);
      check("idle_tokens", 64'(tokens), 64'd8);
      check("idle_orders_sent", 64'(orders_sent), 64'h0);
      check("idle_throttle", 64'(throttle_cycles), 64'h0);

      // Single order from engine 2.
      req_price[2*64 +: 64] = 64'h0000_1234_0000_0000;
      req_side[2]           = 1'b1;
      pend[2]               = 1;
      update_req();
      grants.push_back(2);
      tick();
      check("single_hdr_valid", 64'(tx_valid), 64'h1);
      check("single_hdr_data", tx_data, 64'hDEADBEEF_0102_0001);
      drain(20);
      check("single_orders_sent", 64'(orders_sent), 64'd1);
      check("single_tokens", 64'(tokens), 64'd7);

      // All engines requesting: round-robin order and 4-cycle cadence.
      do_reset();
      for (int i = 0; i < N; i++) begin
         req_price[64*i +: 64] = {32'(i + 1) * 32'h0101_0101, 32'hCAFE_0000 | 32'(i)};
         pend[i] = 2;
      end
      req_side = 4'b1010;
      update_req();
      for (int r = 0; r < 2; r++)
         for (int i = 0; i < N; i++) grants.push_back(i);
      drain(60);
      check("rr_orders_sent", 64'(orders_sent), 64'd8);
      check("rr_tokens", 64'(tokens), 64'd0);
      check("rr_cadence", 64'(last_acc_cyc), 64'd28);

      // Token exhaustion: ten orders from one engine.
      do_reset();
      req_price[1*64 +: 64] = 64'h0000_0000_00BE_EF01;
      req_side[1]           = 1'b0;
      pend[1]               = 10;
      update_req();
      for (int i = 0; i < 10; i++) grants.push_back(1);
      wait_sent(8, 60);
      check("exh_orders_sent", 64'(orders_sent), 64'd8);
      tick();
      check("exh_tokens", 64'(tokens), 64'd0);
      for (int i = 0; i < 100 && grants.size() > 1; i++) tick();
      check("exh_ninth_grant_cycle", 64'(last_acc_cyc), 64'd64);
      check("exh_throttle_first", 64'(throttle_cycles), 64'd32);
      drain(150);
      check("exh_tenth_grant_cycle", 64'(last_acc_cyc), 64'd128);
      check("exh_throttle_total", 64'(throttle_cycles), 64'd92);
      check("exh_orders_total", 64'(orders_sent), 64'd10);

      // Backpressure while the header is on the port.
      do_reset();
      tx_ready              = 1'b0;
      req_price[3*64 +: 64] = 64'h7777_0000_1111_2222;
      req_side[3]           = 1'b1;
      pend[3]               = 1;
      update_req();
      grants.push_back(3);
      tick();
      for (int i = 0; i < 5; i++) begin
         tick();
         check("bp_hdr_valid", 64'(tx_valid), 64'h1);
         check("bp_hdr_hold", tx_data, 64'hDEADBEEF_0103_0001);
      end
      tx_ready = 1'b1;
      drain(20);
      check("bp_orders_sent", 64'(orders_sent), 64'd1);

      // halt raised during the price beat.
      do_reset();
      req_price[0*64 +: 64] = 64'h0000_0000_0000_00A0;
      req_price[1*64 +: 64] = 64'h0000_0000_0000_00B1;
      pend[0] = 1;
      pend[1] = 1;
      update_req();
      grants.push_back(0);
      tick();
      tick();
      halt = 1'b1;
      for (int i = 0; i < 7; i++) tick();
      check("halt_orders_sent", 64'(orders_sent), 64'd1);
      check("halt_throttle", 64'(throttle_cycles), 64'h0);
      check("halt_tx_valid", 64'(tx_valid), 64'h0);
      halt = 1'b0;
      grants.push_back(1);
      drain(20);
      check("halt_resume_sent", 64'(orders_sent), 64'd2);

      // Reset while the header is on the port.
      do_reset();
      pend[2] = 1;
      update_req();
      grants.push_back(2);
      tick();
      check("rst_pre_valid", 64'(tx_valid), 64'h1);
      rst = 1'b1;
      #1;
      check("rst_async_valid", 64'(tx_valid), 64'h0);
      check("rst_async_tokens", 64'(tokens), 64'd8);
      do_reset();
      for (int i = 0; i < 3; i++) tick();
      check("rst_after_valid", 64'(tx_valid), 64'h0);
      check("rst_after_sent", 64'(orders_sent), 64'h0);
      check("rst_after_tokens", 64'(tokens), 64'd8);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
